crc_engine: RTL and testbench
=============================

Name: crc_engine

Overview:
Parametrised CRC peripheral on the picoRV memory-mapped bus (select/wstrb/addr/data_i/ready/data_o). It generalises the fixed CRC-32 unit with:
- compile-time CRC width;
- programmable init and xorout;
- input/output reflection;
- a multi-cycle shift engine that stalls the bus via ready until the data word is absorbed.

Parameters:
- CRC_WIDTH, 32, CRC register width; legal 8..32.
- BITS_PER_CYCLE, 8, data bits absorbed per busy cycle; legal 1, 2, 4, 8.
- DEFAULT_POLY, 32'h04C11DB7, poly reset value, masked to CRC_WIDTH.
- DEFAULT_INIT, 32'hFFFFFFFF, init reset value, masked.
- DEFAULT_XOROUT, 32'hFFFFFFFF, xorout reset value, masked.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- select  in  1  bus transaction valid; held until ready is seen.
- wstrb  in  4  nonzero means write (whole-word write), zero means read.
- addr  in  5  byte offset.
- data_i  in  32  write data.
- ready  out  1  one-cycle transaction completion pulse.
- data_o  out  32  read data; valid while ready=1.

Behaviour:
- Register map (reads zero-extend CRC_WIDTH fields; unmapped reads return 0, unmapped writes are ignored):
  - 0x00 CTRL RW:
    - bit0 INIT: write 1 loads crc=init; self-clears, reads 0.
    - bit1 EN.
    - bits3:2 WSEL: 00=1 byte, 01=2, 10=4, 11=1 byte.
    - bit4 REFIN.
    - bit5 REFOUT.
  - 0x04 POLY RW.
  - 0x08 DATA W, reads 0.
  - 0x0C RESULT R: (REFOUT ? bitrev(crc) : crc) ^ xorout.
  - 0x10 INIT RW.
  - 0x14 XOROUT RW.
  - 0x18 STATUS R: bit0 busy, always 0 when read over the bus.
- Reset:
  - ready=0, data_o=0, CTRL=0.
  - POLY/INIT/XOROUT = defaults.
  - crc=DEFAULT_INIT (masked).
  - FSM=IDLE.
  - Reset mid-BUSY aborts the word; no ready pulse.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: accepts when select=1 and ready was 0 in the previous cycle. This blocks re-acceptance of a held select.
    - Write to DATA with EN=1: latch data word and nbits=8*bytes; go to BUSY.
    - Any other access: perform read/write; go to RESP.
  - BUSY: each cycle absorb BITS_PER_CYCLE bits, MSB-first CRC update:
    - fb = crc[W-1] ^ bit; crc = (crc<<1) ^ (fb ? poly : 0).
    - Bytes are taken LSB byte first (data_i[7:0] first).
    - Within a byte, bit 7 first; if REFIN, bit 0 first.
    - After nbits/BITS_PER_CYCLE cycles, go to RESP.
  - RESP: ready=1 for exactly one cycle, data_o holds read data; then IDLE.
- Latency, counted from the accepting edge:
  - Register access: ready in the next cycle.
  - DATA write: ready after nbits/BITS_PER_CYCLE + 1 cycles (4 bytes at BPC=8 gives 5).
- DATA write with EN=0: no CRC change; ready after 1 cycle.
- CTRL write with INIT=1 and other bits: the other fields are written and crc reloads in the same cycle. INIT takes effect even if EN=0.
- POLY/INIT/XOROUT writes do not alter the running crc.
- Write data is masked to CRC_WIDTH on store; upper bits read 0.

Decomposition:
- Package crc_pkg:
  - register offsets;
  - CTRL bit indices and WSEL encodings;
  - FSM state typedef;
  - bitrev function.
- Sub-module crc_step: combinational BITS_PER_CYCLE-bit update (crc, poly, data bits → next crc), parametrised by CRC_WIDTH and BITS_PER_CYCLE.

Test Plan:
- Reset, then read POLY/INIT/XOROUT/CTRL → 0x04C11DB7, 0xFFFFFFFF, 0xFFFFFFFF, 0x0; each read's ready arrives 1 cycle after select.
- CRC-32 check, W=32:
  - Write CTRL=0x33 (INIT|EN|REFIN|REFOUT, WSEL=00).
  - Write bytes "123456789" (0x31..0x39) one per DATA write.
  - Read RESULT → 0xCBF43926.
- CRC-32/MPEG-2:
  - XOROUT=0, CTRL=0x03.
  - Write DATA 0x34333231 with WSEL=10, then 0x38373635 with WSEL=10, then 0x39 with WSEL=00.
  - Read RESULT → 0x0376E6E7; the 4-byte writes show ready 5 cycles after acceptance at BPC=8 and 33 cycles at BPC=1.
- Narrow instances:
  - CRC_WIDTH=16, DEFAULT_POLY=0x1021, DEFAULT_INIT=0xFFFF, DEFAULT_XOROUT=0: "123456789" → 0x29B1.
  - CRC_WIDTH=8, DEFAULT_POLY=0x07, DEFAULT_INIT=0, DEFAULT_XOROUT=0: "123456789" → 0xF4.
- Held select:
  - Keep select high 3 cycles past ready → exactly one ready pulse and one CRC update.
  - DATA write with EN=0 → RESULT unchanged.
- Assert reset during BUSY → no ready pulse, FSM=IDLE, RESULT reads DEFAULT_INIT ^ DEFAULT_XOROUT = 0x00000000.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared definitions for the CRC peripheral: register map, CTRL layout,
// engine states and a bit-reversal helper.
package crc_pkg;

   localparam logic [4:0] ADDR_CTRL   = 5'h00;
   localparam logic [4:0] ADDR_POLY   = 5'h04;
   localparam logic [4:0] ADDR_DATA   = 5'h08;
   localparam logic [4:0] ADDR_RESULT = 5'h0C;
   localparam logic [4:0] ADDR_INIT   = 5'h10;
   localparam logic [4:0] ADDR_XOROUT = 5'h14;
   localparam logic [4:0] ADDR_STATUS = 5'h18;

   localparam int CTRL_INIT    = 0;
   localparam int CTRL_EN      = 1;
   localparam int CTRL_WSEL_LO = 2;
   localparam int CTRL_WSEL_HI = 3;
   localparam int CTRL_REFIN   = 4;
   localparam int CTRL_REFOUT  = 5;

   localparam logic [1:0] WSEL_1B     = 2'b00;
   localparam logic [1:0] WSEL_2B     = 2'b01;
   localparam logic [1:0] WSEL_4B     = 2'b10;
   localparam logic [1:0] WSEL_1B_ALT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_t;

   // Reverses the low `width` bits of value; bits above width come back zero.
   function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
      logic [31:0] rev;
      rev = {<<{value}};
      return rev >> (32 - width);
   endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational multi-bit CRC advance: absorbs BITS_PER_CYCLE data bits,
// most significant bit of data_bits first, MSB-first shift register form.
module crc_step #(
   parameter int CRC_WIDTH      = 32,
   parameter int BITS_PER_CYCLE = 8
) (
   input  logic [CRC_WIDTH-1:0]      crc,
   input  logic [CRC_WIDTH-1:0]      poly,
   input  logic [BITS_PER_CYCLE-1:0] data_bits,
   output logic [CRC_WIDTH-1:0]      crc_next
);

   logic [CRC_WIDTH-1:0]      c;
   logic [BITS_PER_CYCLE-1:0] bits;
   logic                      fb;

   always_comb begin
      c    = crc;
      bits = data_bits;
      fb   = 1'b0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         fb   = c[CRC_WIDTH-1] ^ bits[BITS_PER_CYCLE-1];
         c    = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? poly : '0);
         bits = bits << 1;
      end
      crc_next = c;
   end

endmodule

// File: rtl/crc_engine.sv
// Memory-mapped CRC peripheral with programmable poly/init/xorout, reflection
// and a multi-cycle shift engine that holds off ready until a word is absorbed.
module crc_engine
   import crc_pkg::*;
#(
   parameter int          CRC_WIDTH      = 32,
   parameter int          BITS_PER_CYCLE = 8,
   parameter logic [31:0] DEFAULT_POLY   = 32'h04C11DB7,
   parameter logic [31:0] DEFAULT_INIT   = 32'hFFFFFFFF,
   parameter logic [31:0] DEFAULT_XOROUT = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        select,
   input  logic [3:0]  wstrb,
   input  logic [4:0]  addr,
   input  logic [31:0] data_i,
   output logic        ready,
   output logic [31:0] data_o
);

   localparam int W = CRC_WIDTH;
   localparam logic [W-1:0] POLY_RST   = DEFAULT_POLY[W-1:0];
   localparam logic [W-1:0] INIT_RST   = DEFAULT_INIT[W-1:0];
   localparam logic [W-1:0] XOROUT_RST = DEFAULT_XOROUT[W-1:0];

   state_t        state_reg, state_next;
   logic [5:0]    ctrl_reg, ctrl_next;
   logic [W-1:0]  poly_reg, poly_next;
   logic [W-1:0]  init_reg, init_next;
   logic [W-1:0]  xorout_reg, xorout_next;
   logic [W-1:0]  crc_reg, crc_next;
   logic [31:0]   stream_reg, stream_next;
   logic [5:0]    steps_reg, steps_next;
   logic [31:0]   data_o_reg, data_o_next;
   logic          hold_reg, hold_next;

   logic [31:0]   stream_in;
   logic [W-1:0]  step_crc;
   logic [31:0]   crc_rev;
   logic [W-1:0]  result_w;
   logic [31:0]   rdata;
   logic          accept;
   int            nbytes;

   // Data bits laid out in absorption order, first bit at stream_in[31].
   genvar gi, gj;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         for (gj = 0; gj < 8; gj++) begin : g_bit
            assign stream_in[31-8*gi-gj] = ctrl_reg[CTRL_REFIN] ? data_i[8*gi+gj]
                                                                 : data_i[8*gi+7-gj];
         end
      end
   endgenerate

   crc_step #(
      .CRC_WIDTH      (W),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .crc       (crc_reg),
      .poly      (poly_reg),
      .data_bits (stream_reg[31 -: BITS_PER_CYCLE]),
      .crc_next  (step_crc)
   );

   assign crc_rev  = bitrev(32'(crc_reg), W);
   assign result_w = (ctrl_reg[CTRL_REFOUT] ? crc_rev[W-1:0] : crc_reg) ^ xorout_reg;

   always_comb begin
      case (addr)
         ADDR_CTRL:   rdata = 32'(ctrl_reg);
         ADDR_POLY:   rdata = 32'(poly_reg);
         ADDR_RESULT: rdata = 32'(result_w);
         ADDR_INIT:   rdata = 32'(init_reg);
         ADDR_XOROUT: rdata = 32'(xorout_reg);
         default:     rdata = '0;
      endcase
   end

   always_comb begin
      case (ctrl_reg[CTRL_WSEL_HI:CTRL_WSEL_LO])
         WSEL_2B: nbytes = 2;
         WSEL_4B: nbytes = 4;
         default: nbytes = 1;
      endcase
   end

   assign ready  = (state_reg == ST_RESP);
   assign data_o = data_o_reg;
   // A select still held after its completion pulse is the same transaction.
   assign accept = (state_reg == ST_IDLE) && select && !ready && !hold_reg;

   always_comb begin
      state_next  = state_reg;
      ctrl_next   = ctrl_reg;
      poly_next   = poly_reg;
      init_next   = init_reg;
      xorout_next = xorout_reg;
      crc_next    = crc_reg;
      stream_next = stream_reg;
      steps_next  = steps_reg;
      data_o_next = '0;
      hold_next   = select && (hold_reg || ready);
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               state_next = ST_RESP;
               if (|wstrb) begin
                  case (addr)
                     ADDR_CTRL: begin
                        ctrl_next = {data_i[5:1], 1'b0};
                        if (data_i[CTRL_INIT]) crc_next = init_reg;
                     end
                     ADDR_POLY:   poly_next   = data_i[W-1:0];
                     ADDR_INIT:   init_next   = data_i[W-1:0];
                     ADDR_XOROUT: xorout_next = data_i[W-1:0];
                     ADDR_DATA: begin
                        if (ctrl_reg[CTRL_EN]) begin
                           stream_next = stream_in;
                           steps_next  = 6'(nbytes * (8 / BITS_PER_CYCLE));
                           state_next  = ST_BUSY;
                        end
                     end
                     default: ;
                  endcase
               end else begin
                  data_o_next = rdata;
               end
            end
         end
         ST_BUSY: begin
            crc_next    = step_crc;
            stream_next = stream_reg << BITS_PER_CYCLE;
            steps_next  = steps_reg - 6'd1;
            if (steps_reg == 6'd1) state_next = ST_RESP;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         ctrl_reg   <= '0;
         poly_reg   <= POLY_RST;
         init_reg   <= INIT_RST;
         xorout_reg <= XOROUT_RST;
         crc_reg    <= INIT_RST;
         stream_reg <= '0;
         steps_reg  <= '0;
         data_o_reg <= '0;
         hold_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         ctrl_reg   <= ctrl_next;
         poly_reg   <= poly_next;
         init_reg   <= init_next;
         xorout_reg <= xorout_next;
         crc_reg    <= crc_next;
         stream_reg <= stream_next;
         steps_reg  <= steps_next;
         data_o_reg <= data_o_next;
         hold_reg   <= hold_next;
      end
   end

endmodule

// File: tb/tb_crc_engine.sv
// Bench for crc_engine: four instances (CRC-32 at 8 and 1 bits/cycle, CRC-16,
// CRC-8) driven from a shared vector table plus hand-written corner sequences.
module tb_crc_engine;
   import crc_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  wstrb;
   logic [4:0]  addr;
   logic [31:0] data_i;
   logic [3:0]  sel;
   logic [3:0]  rdy;
   logic [31:0] rd [4];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   crc_engine dut0 (.clk(clk), .reset(reset), .select(sel[0]), .wstrb(wstrb), .addr(addr),
                    .data_i(data_i), .ready(rdy[0]), .data_o(rd[0]));
   crc_engine #(.BITS_PER_CYCLE(1)) dut1 (.clk(clk), .reset(reset), .select(sel[1]),
                    .wstrb(wstrb), .addr(addr), .data_i(data_i), .ready(rdy[1]), .data_o(rd[1]));
   crc_engine #(.CRC_WIDTH(16), .DEFAULT_POLY(32'h1021), .DEFAULT_INIT(32'hFFFF),
                .DEFAULT_XOROUT(32'h0)) dut2 (.clk(clk), .reset(reset), .select(sel[2]),
                    .wstrb(wstrb), .addr(addr), .data_i(data_i), .ready(rdy[2]), .data_o(rd[2]));
   crc_engine #(.CRC_WIDTH(8), .DEFAULT_POLY(32'h07), .DEFAULT_INIT(32'h0),
                .DEFAULT_XOROUT(32'h0)) dut3 (.clk(clk), .reset(reset), .select(sel[3]),
                    .wstrb(wstrb), .addr(addr), .data_i(data_i), .ready(rdy[3]), .data_o(rd[3]));

   typedef struct {
      int          dut;
      bit          we;
      logic [4:0]  a;
      logic [31:0] wd;
      logic [31:0] exp_d;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      bit          chk_d;
      int          lat;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];

   function automatic void add(input int d, input bit we, input logic [4:0] a,
                               input logic [31:0] wd, input logic [31:0] ed, input int lat);
      vec_t v;
      v.dut = d; v.we = we; v.a = a; v.wd = wd; v.exp_d = ed; v.exp_lat = lat;
      vecs.push_back(v);
   endfunction

   // Bit-serial reference CRC over the first len bytes of msg (byte 0 in msg[7:0]).
   function automatic logic [31:0] model_crc(input logic [71:0] msg, input int len, input int w,
                                             input logic [31:0] poly, input logic [31:0] init,
                                             input logic [31:0] xo, input bit ri, input bit ro);
      logic [31:0] c, r, mask;
      logic [7:0]  cur;
      logic        bt, fb;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      c = (init & mask) << (32 - w);
      for (int n = 0; n < len; n++) begin
         cur = 8'(msg >> (8 * n));
         for (int b = 0; b < 8; b++) begin
            bt  = ri ? cur[0] : cur[7];
            cur = ri ? (cur >> 1) : (cur << 1);
            fb  = c[31] ^ bt;
            c   = (c << 1) ^ (fb ? ((poly & mask) << (32 - w)) : 32'h0);
         end
      end
      c = c >> (32 - w);
      if (ro) begin
         r = '0;
         for (int i = 0; i < w; i++) begin
            r = (r << 1) | (c & 32'h1);
            c = c >> 1;
         end
         c = r;
      end
      return (c ^ xo) & mask;
   endfunction

   task automatic xfer(input int d, input bit we, input logic [4:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input int lat, input int hold_extra);
      sb_t e;
      int  cyc, extra;
      bit  got;
      @(negedge clk);
      sel = '0; sel[d] = 1'b1;
      wstrb = we ? 4'hF : 4'h0; addr = a; data_i = wd;
      e.d = ed; e.chk_d = !we; e.lat = lat;
      sb.push_back(e);
      cyc = 0; got = 1'b0;
      while (!got && cyc < 200) begin
         @(posedge clk); @(negedge clk);
         cyc++;
         got = rdy[d];
      end
      e = sb.pop_front();
      $display("[TB] dut%0d %s addr=%02h wdata=%08h rdata=%08h ready_after=%0d",
               d, we ? "WR" : "RD", a, wd, rd[d], cyc);
      n_tests++;
      if (!got || cyc != e.lat) begin
         n_fail++;
         $display("FAIL latency dut%0d addr=%02h: ready after %0d cycles (seen=%0b), required %0d",
                  d, a, cyc, got, e.lat);
      end
      if (e.chk_d) begin
         n_tests++;
         if (rd[d] !== e.d) begin
            n_fail++;
            $display("FAIL rdata dut%0d addr=%02h: got %08h, required %08h", d, a, rd[d], e.d);
         end
      end
      extra = 0;
      for (int i = 0; i < hold_extra; i++) begin
         @(posedge clk); @(negedge clk);
         if (rdy[d]) extra++;
      end
      if (hold_extra > 0) begin
         n_tests++;
         if (extra != 0) begin
            n_fail++;
            $display("FAIL held_select dut%0d: %0d extra ready pulses, required 0", d, extra);
         end
      end
      sel = '0;
   endtask

   logic [71:0] msg;
   int          pulses;

   initial begin
      msg    = 72'h39_38_37_36_35_34_33_32_31;
      reset  = 1'b1;
      sel    = '0;
      wstrb  = '0;
      addr   = '0;
      data_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      n_tests++;
      if (rdy !== 4'b0 || rd[0] !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%b data_o=%08h, required 0000 / 00000000", rdy, rd[0]);
      end

      // Reset values and unmapped/write-only reads
      add(0, 0, ADDR_POLY,   0, 32'h04C11DB7, 1);
      add(0, 0, ADDR_INIT,   0, 32'hFFFFFFFF, 1);
      add(0, 0, ADDR_XOROUT, 0, 32'hFFFFFFFF, 1);
      add(0, 0, ADDR_CTRL,   0, 32'h0, 1);
      add(0, 0, ADDR_STATUS, 0, 32'h0, 1);
      add(0, 0, ADDR_RESULT, 0, 32'h0, 1);
      add(0, 0, ADDR_DATA,   0, 32'h0, 1);
      add(0, 0, 5'h1C,       0, 32'h0, 1);
      // CRC-32, byte at a time with reflection
      add(0, 1, ADDR_CTRL, 32'h33, 0, 1);
      add(0, 0, ADDR_CTRL, 0, 32'h32, 1);
      for (int k = 0; k < 9; k++) add(0, 1, ADDR_DATA, 32'h31 + k, 0, 2);
      add(0, 0, ADDR_RESULT, 0, 32'hCBF43926, 1);
      // CRC-32/MPEG-2 with word writes at 8 and 1 bits per cycle
      for (int d = 0; d < 2; d++) begin
         add(d, 1, ADDR_XOROUT, 32'h0, 0, 1);
         add(d, 1, ADDR_CTRL, 32'h0B, 0, 1);
         add(d, 1, ADDR_DATA, 32'h34333231, 0, (d == 0) ? 5 : 33);
         add(d, 1, ADDR_DATA, 32'h38373635, 0, (d == 0) ? 5 : 33);
         add(d, 1, ADDR_CTRL, 32'h02, 0, 1);
         add(d, 1, ADDR_DATA, 32'h39, 0, (d == 0) ? 2 : 9);
         add(d, 0, ADDR_RESULT, 0, 32'h0376E6E7, 1);
      end
      // Narrow instances, including masking of stored fields
      add(2, 0, ADDR_POLY, 0, 32'h1021, 1);
      add(2, 1, ADDR_POLY, 32'hFFFF1021, 0, 1);
      add(2, 0, ADDR_POLY, 0, 32'h1021, 1);
      add(2, 1, ADDR_CTRL, 32'h03, 0, 1);
      for (int k = 0; k < 9; k++) add(2, 1, ADDR_DATA, 32'h31 + k, 0, 2);
      add(2, 0, ADDR_RESULT, 0, 32'h29B1, 1);
      add(3, 1, ADDR_CTRL, 32'h03, 0, 1);
      for (int k = 0; k < 9; k++) add(3, 1, ADDR_DATA, 32'h31 + k, 0, 2);
      add(3, 0, ADDR_RESULT, 0, 32'hF4, 1);

      foreach (vecs[i])
         xfer(vecs[i].dut, vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].exp_d, vecs[i].exp_lat, 0);

      // Held select gives one pulse and one update; EN=0 DATA write leaves crc alone
      xfer(0, 1, ADDR_XOROUT, 32'hFFFFFFFF, 0, 1, 0);
      xfer(0, 1, ADDR_CTRL, 32'h33, 0, 1, 0);
      xfer(0, 1, ADDR_DATA, 32'h31, 0, 2, 3);
      xfer(0, 0, ADDR_RESULT, 0,
           model_crc(msg, 1, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1), 1, 0);
      xfer(0, 1, ADDR_CTRL, 32'h30, 0, 1, 0);
      xfer(0, 1, ADDR_DATA, 32'h32, 0, 1, 0);
      xfer(0, 0, ADDR_RESULT, 0,
           model_crc(msg, 1, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1), 1, 0);
      xfer(0, 1, ADDR_CTRL, 32'h32, 0, 1, 0);
      xfer(0, 1, ADDR_DATA, 32'h32, 0, 2, 0);
      xfer(0, 0, ADDR_RESULT, 0,
           model_crc(msg, 2, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1), 1, 0);
      // Init on a narrow instance with EN clear still reloads crc
      xfer(2, 1, ADDR_INIT, 32'h1234ABCD, 0, 1, 0);
      xfer(2, 1, ADDR_CTRL, 32'h01, 0, 1, 0);
      xfer(2, 0, ADDR_RESULT, 0, 32'hABCD, 1, 0);

      // Reset while BUSY aborts the word with no completion pulse
      xfer(1, 1, ADDR_CTRL, 32'h0B, 0, 1, 0);
      @(negedge clk);
      sel = 4'b0010; wstrb = 4'hF; addr = ADDR_DATA; data_i = 32'hDEADBEEF;
      repeat (5) @(negedge clk);
      reset = 1'b1; sel = '0;
      @(negedge clk);
      reset = 1'b0;
      $display("[TB] dut1 WR addr=08 wdata=deadbeef aborted by reset");
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rdy != 4'b0) pulses++;
      end
      n_tests++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL reset_abort: %0d cycles with ready after reset, required 0", pulses);
      end
      xfer(1, 0, ADDR_RESULT, 0, 32'h0, 1, 0);
      xfer(1, 0, ADDR_XOROUT, 0, 32'hFFFFFFFF, 1, 0);
      xfer(1, 0, ADDR_CTRL, 0, 32'h0, 1, 0);
      xfer(0, 0, ADDR_RESULT, 0, 32'h0, 1, 0);
      xfer(2, 0, ADDR_RESULT, 0, 32'hFFFF, 1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
